wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
Writeback arbiter directly upstream of the register file write port (WE, A3_WB, WD3_SCA, WD3_VEC). It merges scalar/vector ALU results and memory-load results onto the single write port. ALU results have strict priority; load results wait in an in-order FIFO. It also reports pending-write hazards on the decode read addresses so decode can stall.

Parameters:
DW, 4, element width in bits (scalar register width, also vector lane width)
LANES, 2, vector lanes per vector register
AW, 5, register address width
DEPTH, 4, load FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
alu_valid  in  1  ALU result present this cycle; always accepted, no backpressure
alu_addr  in  AW  ALU destination register
alu_wd_sca  in  DW  ALU scalar result
alu_wd_vec  in  LANES*DW  ALU vector result, packed [LANES-1:0][DW-1:0]
mem_valid  in  1  load result offered
mem_ready  out  1  FIFO can accept; equals !full
mem_addr  in  AW  load destination register
mem_wd_sca  in  DW  load scalar data
mem_wd_vec  in  LANES*DW  load vector data
A1, A2  in  AW  decode read addresses
HAZ1, HAZ2  out  1  pending write to A1/A2 (combinational)
WE  out  1  register file write enable (registered)
A3_WB  out  AW  write address (registered)
WD3_SCA  out  DW  scalar write data (registered)
WD3_VEC  out  LANES*DW  vector write data (registered)
fifo_count  out  $clog2(DEPTH)+1  FIFO occupancy
addr_err  out  1  sticky flag: illegal destination seen

Behaviour:
- Address map: 1-15 scalar, 16-23 vector (addr[4]=1), 0 reserved, 24-31 illegal.
- Reset (rst=0, async): WE=0, A3_WB=0, WD3_SCA=0, WD3_VEC=0, FIFO empty, fifo_count=0, mem_ready=1, addr_err=0.
- Push: mem_valid & mem_ready at the clock edge stores {addr, sca, vec}. mem_ready is derived from registered count only, so a pop in the same cycle does not free a slot for a push while full.
- Select each cycle: if alu_valid, the ALU source wins. Else if the FIFO is non-empty, pop the head. Else nothing is selected.
- Output register: the selected entry appears on WE/A3_WB/WD3_* at the next rising edge (latency 1). With no selection, WE=0 and the data/address outputs hold their last values.
- Dropped writes: a selected entry with address 0 or 24-31 is consumed (a FIFO entry is still popped) but WE=0. Address 24-31 also sets addr_err, which clears only on reset.
- Data routing: both WD3_SCA and WD3_VEC carry the source data unchanged. The register file picks one by addr[4].
- Simultaneous push and pop on a non-empty, non-full FIFO: count unchanged, order preserved.
- Empty FIFO with ALU idle and mem push in the same cycle: no bypass. The entry is written one cycle later via the FIFO.
- Starvation: continuous alu_valid starves the FIFO indefinitely. Upstream guarantees ALU gaps, and the block does not track starvation.
- Hazards: HAZn=1 when An != 0 and An matches the address of any valid FIFO entry, or of the output stage while WE=1, or alu_addr while alu_valid=1.
- WAW ordering: decode stalls on HAZn, so the ALU never targets a register with an older pending load.
- Pointers wrap modulo DEPTH. fifo_count saturates at DEPTH by construction.
- Reset mid-operation: FIFO contents are discarded and the in-flight output write is cancelled (WE=0 immediately).

Decomposition:
- Shared package wb_pkg: DW, LANES, AW, and the address-map constants SCA_BASE=1, VEC_BASE=16, VEC_LAST=23.
- wb_pkg also holds typedef vec_t (logic [LANES-1:0][DW-1:0]) and typedef wb_entry_t (struct {addr, sca, vec}).
- One sub-module, wb_fifo: parameterised circular buffer of wb_entry_t with push/pop/count/full/empty.
- wb_fifo also exposes all entries plus a valid mask for the hazard compare.

Test Plan:
- Reset then idle: WE=0, mem_ready=1, fifo_count=0 at every cycle.
- Scalar ALU write: alu_valid=1, alu_addr=5, alu_wd_sca=4'hF -> next cycle WE=1, A3_WB=5, WD3_SCA=4'hF. Register file RD1_SCA reads 4'hF one cycle after.
- Contention: alu_valid continuous for 6 cycles while mem pushes addr 16..20 with vec {4'hC,4'hA}.
  - mem_ready falls after 4 pushes (fifo_count=4).
  - After ALU stops, four WE pulses follow in order to addresses 16,17,18,19.
  - Then the 5th push (addr 20) is accepted and written.
- Hazard: FIFO holds a load to 17, A1=17, A2=3 -> HAZ1=1, HAZ2=0. HAZ1 drops the cycle after addr 17 is written.
- Illegal/reserved: ALU addr 0 -> WE stays 0, addr_err=0. Load addr 25 -> entry popped, WE=0, addr_err=1 until rst=0.
- Async reset with fifo_count=3 and WE=1: assert rst=0 mid-cycle -> WE=0 and fifo_count=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths, address map and entry types for the writeback arbiter
package wb_pkg;

  localparam int DW    = 4;
  localparam int LANES = 2;
  localparam int AW    = 5;

  localparam logic [AW-1:0] SCA_BASE = 5'd1;
  localparam logic [AW-1:0] VEC_BASE = 5'd16;
  localparam logic [AW-1:0] VEC_LAST = 5'd23;

  typedef logic [LANES-1:0][DW-1:0] vec_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] sca;
    vec_t          vec;
  } wb_entry_t;

  // Address 0 is reserved and 24-31 are illegal; only 1-23 reach the register file.
  function automatic logic addr_writable(input logic [AW-1:0] a);
    return (a >= SCA_BASE) && (a <= VEC_LAST);
  endfunction

  function automatic logic addr_illegal(input logic [AW-1:0] a);
    return a > VEC_LAST;
  endfunction

  function automatic logic addr_is_vec(input logic [AW-1:0] a);
    return (a >= VEC_BASE) && (a <= VEC_LAST);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - in-order circular buffer of load results with entry visibility for hazard checks
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  wb_entry_t                     push_data,
  input  logic                          pop,
  output wb_entry_t                     head,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(DEPTH):0]        count,
  output wb_entry_t [DEPTH-1:0]         entries,
  output logic [DEPTH-1:0]              valid_mask
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t [DEPTH-1:0] mem;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];
  assign entries = mem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Payload storage needs no reset; validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    valid_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PW-1:0] off;
      off = PW'(i) - rd_ptr;
      valid_mask[i] = ({1'b0, off} < count);
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - merges ALU and load results onto the register file write port
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_valid,
  input  logic [AW-1:0]          alu_addr,
  input  logic [DW-1:0]          alu_wd_sca,
  input  logic [LANES*DW-1:0]    alu_wd_vec,
  input  logic                   mem_valid,
  output logic                   mem_ready,
  input  logic [AW-1:0]          mem_addr,
  input  logic [DW-1:0]          mem_wd_sca,
  input  logic [LANES*DW-1:0]    mem_wd_vec,
  input  logic [AW-1:0]          A1,
  input  logic [AW-1:0]          A2,
  output logic                   HAZ1,
  output logic                   HAZ2,
  output logic                   WE,
  output logic [AW-1:0]          A3_WB,
  output logic [DW-1:0]          WD3_SCA,
  output logic [LANES*DW-1:0]    WD3_VEC,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   addr_err
);

  wb_entry_t             push_data;
  wb_entry_t             alu_entry;
  wb_entry_t             fifo_head;
  wb_entry_t             sel;
  wb_entry_t [DEPTH-1:0] fifo_entries;
  logic [DEPTH-1:0]      fifo_valid;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic                  sel_valid;
  logic [AW-1:0]         rd_addr [2];
  logic [1:0]            haz;

  assign push_data = '{addr: mem_addr, sca: mem_wd_sca, vec: mem_wd_vec};
  assign alu_entry = '{addr: alu_addr, sca: alu_wd_sca, vec: alu_wd_vec};

  // Readiness depends only on the registered count: a same-cycle pop never frees a slot.
  assign mem_ready = !fifo_full;
  assign push      = mem_valid && mem_ready;

  // ALU has strict priority; the FIFO drains only in ALU gaps.
  assign pop       = !alu_valid && !fifo_empty;
  assign sel_valid = alu_valid || !fifo_empty;
  assign sel       = alu_valid ? alu_entry : fifo_head;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_data  (push_data),
    .pop        (pop),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count),
    .entries    (fifo_entries),
    .valid_mask (fifo_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      WE       <= 1'b0;
      A3_WB    <= '0;
      WD3_SCA  <= '0;
      WD3_VEC  <= '0;
      addr_err <= 1'b0;
    end else begin
      WE <= sel_valid && addr_writable(sel.addr);
      if (sel_valid) begin
        A3_WB   <= sel.addr;
        WD3_SCA <= sel.sca;
        WD3_VEC <= sel.vec;
      end
      if (sel_valid && addr_illegal(sel.addr)) addr_err <= 1'b1;
    end
  end

  assign rd_addr[0] = A1;
  assign rd_addr[1] = A2;

  // A read is hazardous if any queued load, the output stage or the current ALU result targets it.
  always_comb begin
    haz = '0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (fifo_valid[i] && (fifo_entries[i].addr == rd_addr[p])) haz[p] = 1'b1;
      end
      if (WE && (A3_WB == rd_addr[p]))           haz[p] = 1'b1;
      if (alu_valid && (alu_addr == rd_addr[p])) haz[p] = 1'b1;
      if (rd_addr[p] == '0)                      haz[p] = 1'b0;
    end
  end

  assign HAZ1 = haz[0];
  assign HAZ2 = haz[1];

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for wb_arbiter against a queue-based model
module tb_wb_arbiter;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       alu_valid;
  logic [4:0] alu_addr;
  logic [3:0] alu_wd_sca;
  logic [7:0] alu_wd_vec;
  logic       mem_valid;
  logic       mem_ready;
  logic [4:0] mem_addr;
  logic [3:0] mem_wd_sca;
  logic [7:0] mem_wd_vec;
  logic [4:0] A1, A2;
  logic       HAZ1, HAZ2;
  logic       WE;
  logic [4:0] A3_WB;
  logic [3:0] WD3_SCA;
  logic [7:0] WD3_VEC;
  logic [2:0] fifo_count;
  logic       addr_err;

  int n_pass  = 0;
  int n_total = 0;

  wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_addr   (alu_addr),
    .alu_wd_sca (alu_wd_sca),
    .alu_wd_vec (alu_wd_vec),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_wd_sca (mem_wd_sca),
    .mem_wd_vec (mem_wd_vec),
    .A1         (A1),
    .A2         (A2),
    .HAZ1       (HAZ1),
    .HAZ2       (HAZ2),
    .WE         (WE),
    .A3_WB      (A3_WB),
    .WD3_SCA    (WD3_SCA),
    .WD3_VEC    (WD3_VEC),
    .fifo_count (fifo_count),
    .addr_err   (addr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: a plain queue of pending loads plus the last write seen by the register file.
  typedef struct {
    logic [4:0] a;
    logic [3:0] s;
    logic [7:0] v;
  } ent_t;

  ent_t       q[$];
  logic       m_we, m_err;
  logic [4:0] m_a3;
  logic [3:0] m_sca;
  logic [7:0] m_vec;

  always @(posedge clk or negedge rst) begin
    ent_t e;
    logic have, accept;
    if (!rst) begin
      q.delete();
      m_we = 1'b0; m_err = 1'b0; m_a3 = '0; m_sca = '0; m_vec = '0;
    end else begin
      accept = mem_valid && (q.size() < DEPTH);
      have = 1'b1;
      if (alu_valid) e = '{alu_addr, alu_wd_sca, alu_wd_vec};
      else if (q.size() > 0) e = q.pop_front();
      else have = 1'b0;
      if (accept) q.push_back('{mem_addr, mem_wd_sca, mem_wd_vec});
      m_we = have && (e.a >= 1) && (e.a <= 23);
      if (have) begin m_a3 = e.a; m_sca = e.s; m_vec = e.v; end
      if (have && e.a >= 24) m_err = 1'b1;
    end
  end

  function automatic logic m_haz(input logic [4:0] an);
    logic h;
    h = 1'b0;
    foreach (q[i]) if (q[i].a == an) h = 1'b1;
    if (m_we && m_a3 == an) h = 1'b1;
    if (alu_valid && alu_addr == an) h = 1'b1;
    return (an != 0) && h;
  endfunction

  always @(negedge clk) begin
    chk("we", WE, m_we);
    chk("ready", mem_ready, q.size() < DEPTH);
    chk("count", fifo_count, q.size());
    chk("err", addr_err, m_err);
    chk("haz1", HAZ1, m_haz(A1));
    chk("haz2", HAZ2, m_haz(A2));
    if (m_we) begin
      chk("a3", A3_WB, m_a3);
      chk("sca", WD3_SCA, m_sca);
      chk("vec", WD3_VEC, m_vec);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_addr = 0; alu_wd_sca = 0; alu_wd_vec = 0;
    mem_valid = 0; mem_addr = 0; mem_wd_sca = 0; mem_wd_vec = 0;
    A1 = 0; A2 = 0;
  endtask

  initial begin
    logic [4:0] log_a[$];
    logic [4:0] exp_order [11];
    int k;
    logic acc;
    exp_order = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd16, 5'd17, 5'd18, 5'd19, 5'd20};

    idle_inputs();
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;

    repeat (3) begin
      tick();
      chk("idle_we", WE, 1'b0);
      chk("idle_ready", mem_ready, 1'b1);
      chk("idle_count", fifo_count, 3'd0);
    end

    // Scalar ALU write lands one cycle later
    alu_valid = 1; alu_addr = 5; alu_wd_sca = 4'hF;
    tick();
    chk("alu_we", WE, 1'b1);
    chk("alu_a3", A3_WB, 5'd5);
    chk("alu_sca", WD3_SCA, 4'hF);
    idle_inputs();
    tick();

    // Contention: six ALU cycles while five loads try to enter
    k = 0;
    for (int c = 0; c < 40; c++) begin
      alu_valid = (c < 6); alu_addr = 5'(c + 1); alu_wd_sca = 4'(c);
      mem_valid = (k < 5); mem_addr = 5'(16 + k); mem_wd_sca = 4'(k); mem_wd_vec = {4'hC, 4'hA};
      acc = mem_valid && mem_ready;
      tick();
      if (acc) k++;
      if (WE) begin
        log_a.push_back(A3_WB);
        if (A3_WB == 5'd16) chk("vec16", WD3_VEC, 8'hCA);
      end
      if (c == 3) begin
        chk("full_count", fifo_count, 3'd4);
        chk("full_ready", mem_ready, 1'b0);
      end
    end
    idle_inputs();
    chk("pushes_done", k, 5);
    chk("we_pulses", log_a.size(), 11);
    for (int i = 0; i < 11; i++) begin
      if (i < log_a.size()) chk("order", log_a[i], exp_order[i]);
    end

    // Hazard against a queued load to 17
    alu_valid = 1; alu_addr = 2; mem_valid = 1; mem_addr = 17; mem_wd_vec = 8'h35;
    tick();
    mem_valid = 0; alu_addr = 4; A1 = 17; A2 = 3;
    tick();
    chk("haz1_q", HAZ1, 1'b1);
    chk("haz2_q", HAZ2, 1'b0);
    alu_valid = 0;
    tick();
    chk("haz_we17", WE, 1'b1);
    chk("haz_a3", A3_WB, 5'd17);
    chk("haz1_out", HAZ1, 1'b1);
    tick();
    chk("haz1_clear", HAZ1, 1'b0);
    idle_inputs();

    // Reserved and illegal destinations
    alu_valid = 1; alu_addr = 0;
    tick();
    alu_valid = 0;
    chk("rsv_we", WE, 1'b0);
    chk("rsv_err", addr_err, 1'b0);
    mem_valid = 1; mem_addr = 25;
    tick();
    mem_valid = 0;
    chk("ill_count1", fifo_count, 3'd1);
    tick();
    chk("ill_we", WE, 1'b0);
    chk("ill_err", addr_err, 1'b1);
    chk("ill_count0", fifo_count, 3'd0);
    tick();
    chk("ill_err_sticky", addr_err, 1'b1);

    // Async reset mid-cycle with three loads queued and a write in flight
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1; alu_addr = 7; mem_valid = 1; mem_addr = 5'(9 + i);
      tick();
    end
    chk("pre_rst_count", fifo_count, 3'd3);
    chk("pre_rst_we", WE, 1'b1);
    idle_inputs();
    #1 rst = 1'b0;
    #1;
    chk("rst_we", WE, 1'b0);
    chk("rst_count", fifo_count, 3'd0);
    chk("rst_err", addr_err, 1'b0);
    chk("rst_ready", mem_ready, 1'b1);
    tick();
    rst = 1'b1;
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
